// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch unit with a prefetch queue. Drives a PC-addressed
// synchronous instruction memory (data returns one cycle after the request),
// buffers up to DEPTH returned instructions together with the PC each was
// fetched from, and presents the queue head to the control unit, split into
// opcode and address fields, over a valid/ready handshake. A redirect flushes
// all buffered and in-flight work and restarts fetching at redirect_pc.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined     -> stall_cnt counts cycles where the consumer is ready but the
//                  queue is empty (no redirect); saturates at 0xFFFF, cleared
//                  only by reset.
//   not defined -> stall_cnt is tied to 0.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   fetch_ce     in   fetch enable, gates issue of new memory requests only
//   imem_req     out  memory read request this cycle
//   imem_addr    out  memory read address (current PC)
//   imem_rdata   in   memory read data, valid the cycle after imem_req
//   redirect     in   flush and restart at redirect_pc
//   redirect_pc  in   new fetch PC
//   out_valid    out  queue head holds an instruction
//   out_ready    in   consumer accepts head
//   out_opcode   out  head opcode field (top OPCODE_W bits)
//   out_address  out  head address field (remaining low bits)
//   out_pc       out  PC the head instruction was fetched from
//   stall_cnt    out  starvation counter (see macro above)
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          INSTR_W  = 16,
  parameter int          OPCODE_W = 4,
  parameter int          PC_W     = 12,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_ce,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPCODE_W-1:0]          out_opcode,
  output logic [INSTR_W-OPCODE_W-1:0]  out_address,
  output logic [PC_W-1:0]              out_pc,
  output logic [15:0]                  stall_cnt
);

  localparam int ADDR_W = INSTR_W - OPCODE_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_req_pc;
  logic               r_inflight;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W-1:0]   r_wptr;
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_epc   [DEPTH];

  logic [CNT_W-1:0]   w_used;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [INSTR_W-1:0] w_head;

  // Credits: queued entries plus the one possibly returning next cycle must
  // leave room, so a return can never land on a full queue.
  assign w_used  = r_count + CNT_W'(r_inflight);
  assign w_issue = fetch_ce & ~redirect & (w_used < CNT_W'(DEPTH));
  assign w_push  = r_inflight & ~redirect;
  assign w_pop   = out_valid & out_ready & ~redirect;

  // Gated by rst_n so no request leaks out while reset is held.
  assign imem_req  = rst_n & w_issue;
  assign imem_addr = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= PC_W'(RESET_PC);
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rptr     <= '0;
      r_wptr     <= '0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rptr     <= '0;
      r_wptr     <= '0;
    end else begin
      if (w_issue) begin
        r_pc     <= r_pc + PC_W'(1);
        r_req_pc <= r_pc;
      end
      r_inflight <= w_issue;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is reset so the head fields read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_epc[i]   <= '0;
      end
    end else if (w_push) begin
      r_instr[r_wptr] <= imem_rdata;
      r_epc[r_wptr]   <= r_req_pc;
    end
  end

  assign out_valid   = (r_count != '0);
  assign w_head      = r_instr[r_rptr];
  assign out_opcode  = w_head[INSTR_W-1 -: OPCODE_W];
  assign out_address = w_head[ADDR_W-1:0];
  assign out_pc      = r_epc[r_rptr];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_ready && !out_valid && !redirect && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ce;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [11:0] out_address;
  logic [11:0] out_pc;
  logic [15:0] stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [15:0] STALL5 = 16'd5;
`else
  localparam logic [15:0] STALL5 = 16'd0;
`endif

  fetch_queue #(
    .INSTR_W (16),
    .OPCODE_W(4),
    .PC_W    (12),
    .DEPTH   (4),
    .RESET_PC(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_ce   (fetch_ce),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_address(out_address),
    .out_pc     (out_pc),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous memory: instruction word is 0xA000 | address.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 16'hA000 | {4'h0, imem_addr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_ce = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #2;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_req",   32'(imem_req),  32'h0);
    check("rst_addr",  32'(imem_addr), 32'h0);
    check("rst_opc",   32'(out_opcode), 32'h0);
    check("rst_pc",    32'(out_pc),    32'h0);
    check("rst_stall", 32'(stall_cnt), 32'h0);
    tick(); tick();

    // Release reset; consumer ready, no fetching -> starvation cycles.
    rst_n = 1'b1; out_ready = 1'b1; #1;
    check("rel_valid", 32'(out_valid), 32'h0);
    check("rel_req",   32'(imem_req),  32'h0);
    check("rel_stall", 32'(stall_cnt), 32'h0);
    repeat (5) tick();
    #1;
    check("stall5", 32'(stall_cnt), 32'(STALL5));

    // Streaming fetch from PC 0.
    fetch_ce = 1'b1; #1;
    check("c0_req",   32'(imem_req),  32'h1);
    check("c0_addr",  32'(imem_addr), 32'h000);
    check("c0_valid", 32'(out_valid), 32'h0);
    tick(); #1;
    check("c1_addr",  32'(imem_addr), 32'h001);
    check("c1_valid", 32'(out_valid), 32'h0);
    tick(); #1;
    check("c2_valid", 32'(out_valid),   32'h1);
    check("c2_opc",   32'(out_opcode),  32'hA);
    check("c2_adr",   32'(out_address), 32'h000);
    check("c2_pc",    32'(out_pc),      32'h000);
    check("c2_addr",  32'(imem_addr),   32'h002);
    tick(); #1;
    check("c3_valid", 32'(out_valid),   32'h1);
    check("c3_pc",    32'(out_pc),      32'h001);
    check("c3_adr",   32'(out_address), 32'h001);

    // Flush and restart at 0x010 with consumer stalled.
    tick();
    redirect = 1'b1; redirect_pc = 12'h010; out_ready = 1'b0; #1;
    check("c4_redir_req", 32'(imem_req), 32'h0);
    tick();
    redirect = 1'b0; #1;
    check("d0_valid", 32'(out_valid), 32'h0);
    check("d0_req",   32'(imem_req),  32'h1);
    check("d0_addr",  32'(imem_addr), 32'h010);
    tick(); tick(); #1;
    check("d2_valid", 32'(out_valid), 32'h1);
    check("d2_pc",    32'(out_pc),    32'h010);
    tick(); #1;
    check("d3_req",   32'(imem_req),  32'h1);
    check("d3_addr",  32'(imem_addr), 32'h013);
    tick(); #1;
    check("d4_full_req", 32'(imem_req), 32'h0);
    tick();
    out_ready = 1'b1; #1;
    check("d5_full_req", 32'(imem_req), 32'h0);
    check("d5_pc",       32'(out_pc),   32'h010);
    tick();
    out_ready = 1'b0; #1;
    check("d6_req",  32'(imem_req),  32'h1);
    check("d6_addr", 32'(imem_addr), 32'h014);
    check("d6_pc",   32'(out_pc),    32'h011);

    // Queue holds 3 with one in flight: redirect to 0x123.
    tick();
    redirect = 1'b1; redirect_pc = 12'h123; #1;
    check("d7_req", 32'(imem_req), 32'h0);
    tick();
    redirect = 1'b0; out_ready = 1'b1; #1;
    check("e0_valid", 32'(out_valid), 32'h0);
    check("e0_req",   32'(imem_req),  32'h1);
    check("e0_addr",  32'(imem_addr), 32'h123);
    tick(); #1;
    check("e1_valid", 32'(out_valid), 32'h0);
    check("e1_addr",  32'(imem_addr), 32'h124);
    tick(); #1;
    check("e2_valid", 32'(out_valid),   32'h1);
    check("e2_pc",    32'(out_pc),      32'h123);
    check("e2_adr",   32'(out_address), 32'h123);
    check("e2_opc",   32'(out_opcode),  32'hA);

    // PC wrap from 0xFFE.
    tick();
    redirect = 1'b1; redirect_pc = 12'hFFE; #1;
    check("e3_pc", 32'(out_pc), 32'h124);
    tick();
    redirect = 1'b0; #1;
    check("f0_addr", 32'(imem_addr), 32'hFFE);
    tick(); #1;
    check("f1_addr", 32'(imem_addr), 32'hFFF);
    tick(); #1;
    check("f2_addr", 32'(imem_addr), 32'h000);
    check("f2_pc",   32'(out_pc),    32'hFFE);
    tick(); #1;
    check("f3_pc", 32'(out_pc), 32'hFFF);

    // fetch_ce dropped with one request in flight.
    tick();
    redirect = 1'b1; redirect_pc = 12'h050; #1;
    check("f4_pc", 32'(out_pc), 32'h000);
    tick();
    redirect = 1'b0; #1;
    check("g0_addr", 32'(imem_addr), 32'h050);
    tick();
    fetch_ce = 1'b0; #1;
    check("g1_req", 32'(imem_req), 32'h0);
    tick(); #1;
    check("g2_valid", 32'(out_valid), 32'h1);
    check("g2_pc",    32'(out_pc),    32'h050);
    check("g2_req",   32'(imem_req),  32'h0);
    tick(); #1;
    check("g3_valid", 32'(out_valid), 32'h0);
    check("g3_req",   32'(imem_req),  32'h0);
    fetch_ce = 1'b1;
    tick(); #1;
    check("g4_addr", 32'(imem_addr), 32'h052);
    tick(); #1;
    check("g5_valid", 32'(out_valid), 32'h1);
    check("g5_pc",    32'(out_pc),    32'h051);

    // Asynchronous reset mid-stream.
    rst_n = 1'b0; #1;
    check("ar_valid", 32'(out_valid),   32'h0);
    check("ar_req",   32'(imem_req),    32'h0);
    check("ar_addr",  32'(imem_addr),   32'h0);
    check("ar_opc",   32'(out_opcode),  32'h0);
    check("ar_adr",   32'(out_address), 32'h0);
    check("ar_pc",    32'(out_pc),      32'h0);
    check("ar_stall", 32'(stall_cnt),   32'h0);
    tick();
    rst_n = 1'b1; #1;
    check("rr_req",   32'(imem_req),  32'h1);
    check("rr_addr",  32'(imem_addr), 32'h000);
    check("rr_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch unit with a prefetch queue, replacing the single-register opcode/address latch. It drives a PC-addressed synchronous instruction memory, buffers up to DEPTH returned instructions, and presents them, already split into opcode and address fields, to the control unit over a valid/ready handshake. A redirect input flushes all buffered and in-flight work and restarts fetching at a new PC. It sits between instruction memory and decode/control.

## Interface
- INSTR_W, 16, instruction width
- OPCODE_W, 4, opcode field width; opcode = instr[INSTR_W-1 -: OPCODE_W], address = remaining low bits
- PC_W, 12, program counter / memory address width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 0, PC value after reset

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_ce  in  1  fetch enable; gates issue of new memory requests only
- imem_req  out  1  read request this cycle
- imem_addr  out  PC_W  read address (current PC)
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after imem_req
- redirect  in  1  flush and load PC from redirect_pc
- redirect_pc  in  PC_W  new fetch PC
- out_valid  out  1  queue head holds an instruction
- out_ready  in  1  consumer accepts head
- out_opcode  out  OPCODE_W  head opcode field
- out_address  out  INSTR_W-OPCODE_W  head address field
- out_pc  out  PC_W  PC the head instruction was fetched from
- stall_cnt  out  16  starvation counter (see Configuration)

## Operation
- State: pc, inflight flag (request issued last cycle), circular queue of DEPTH entries {instr, pc}, read/write pointers, count (0..DEPTH).
- Issue: imem_req = fetch_ce & ~redirect & (count + inflight < DEPTH). On issue pc <= pc + 1 (mod 2^PC_W, 0xFFF wraps to 0x000 at default); inflight <= 1, else inflight <= 0.
- Return: when inflight is 1 and no redirect, {imem_rdata, pc_of_request} is written at the tail. Credit rule guarantees no write to a full queue; no overflow handling required.
- Pop: out_valid & out_ready removes head. Push and pop in the same cycle leave count unchanged.
- out_opcode/out_address/out_pc are driven from the head entry storage; stable while out_valid & ~out_ready.
- Redirect (highest priority): queue emptied (count 0, pointers 0), returning data in that cycle discarded, no request issued, pc <= redirect_pc, inflight <= 0. A handshake occurring in the redirect cycle is void; the consumer must not use it.
- fetch_ce low: no new requests; an in-flight return is still captured; queue drains normally.
- No bypass: data goes through queue storage before appearing on outputs.

## Timing
- Reset values: imem_req 0 (registered state inflight 0, count 0), out_valid 0, out_opcode 0, out_address 0, out_pc 0, pc RESET_PC, imem_addr RESET_PC, stall_cnt 0. Reset is valid at any point, including mid-fetch; no data survives it.
- imem_req/imem_addr are combinational from registered state plus fetch_ce/redirect.
- Latency: request in cycle N -> data written at end of N+1 -> out_valid in N+2.
- Steady state with out_ready held 1: one instruction per cycle, no bubbles.
- First request after redirect in cycle N: cycle N+1 (if fetch_ce), out_valid at N+3.
- Full: count + inflight == DEPTH stops issue; one pop re-enables issue the following cycle.

## Configuration
- FETCH_PERF_CNT_EN defined: stall_cnt increments each cycle with out_ready=1, out_valid=0, redirect=0; saturates at 0xFFFF; cleared only by reset.
- Not defined: stall_cnt tied to 0, no counter logic; all other behaviour identical.

## Test plan
- Reset release, fetch_ce=1, memory returns instr = 0xA000|addr, out_ready=1 -> imem_addr 0,1,2,...; first out_valid 2 cycles after first req, out_opcode 0xA, out_address 0x000, out_pc 0x000, then one per cycle in order.
- out_ready=0 with DEPTH=4 -> exactly 4 requests issued, imem_req then stays 0, count 4; raise out_ready for one cycle -> one request issued next cycle, order preserved.
- redirect=1, redirect_pc=0x123 while queue holds 3 entries and one in flight -> out_valid 0 next cycle, stale data never appears, next imem_addr 0x123, first out_pc 0x123.
- PC 0xFFE start via redirect -> imem_addr 0xFFE, 0xFFF, 0x000; out_pc sequence matches.
- fetch_ce dropped with one request in flight -> that instruction still delivered, no further requests; assert rst_n low mid-stream -> all outputs immediately at reset values.
- With FETCH_PERF_CNT_EN: 5 cycles of out_ready=1 on empty queue after reset -> stall_cnt 5; without macro stall_cnt stays 0.
